// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad encoder: FSM states, digit/key widths.
package keypad_pkg;

    localparam int DIGIT_W = 4;
    localparam int KEY_N   = 10;

    localparam logic [DIGIT_W-1:0] BCD_ZERO = 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        HELD,
        RELEASE
    } kp_state_e;

endpackage

// File: rtl/keypad_encoder_if.sv
// Digit interface between the keypad encoder (slave) and the controller/display side (master).
interface keypad_encoder_if;
    import keypad_pkg::*;

    logic [KEY_N-1:0]   keypad;
    logic               enablen;
    logic               clear;
    logic [DIGIT_W-1:0] Minutes;
    logic [DIGIT_W-1:0] TenSec;
    logic [DIGIT_W-1:0] Sec;
    logic               key_valid;
    logic [DIGIT_W-1:0] key_code;

    modport master (
        output keypad, enablen, clear,
        input  Minutes, TenSec, Sec, key_valid, key_code
    );

    modport slave (
        input  keypad, enablen, clear,
        output Minutes, TenSec, Sec, key_valid, key_code
    );

endinterface

// File: rtl/keypad_onehot_enc.sv
// Combinational one-hot to BCD encoder; hit is low for an empty or multi-key sample.
module keypad_onehot_enc
    import keypad_pkg::*;
(
    input  logic [KEY_N-1:0]   sample_i,
    output logic               hit_o,
    output logic [DIGIT_W-1:0] code_o
);

    always_comb begin
        // x & (x-1) clears the lowest set bit, so zero means at most one bit set
        hit_o  = (sample_i != '0) && ((sample_i & (sample_i - KEY_N'(1))) == '0);
        code_o = BCD_ZERO;
        for (int k = 0; k < KEY_N; k++) begin
            if (sample_i[k]) code_o = DIGIT_W'(k);
        end
        if (!hit_o) code_o = BCD_ZERO;
    end

endmodule

// File: rtl/keypad_encoder.sv
// Debounced 10-key keypad to 3-digit BCD shift-in entry (Minutes:TenSec:Sec).
// Optional KEYPAD_SYNC_EN adds a 2-flop input synchronizer (+2 cycles latency).
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input logic             clk,
    input logic             rst_n,
    keypad_encoder_if.slave kp
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [KEY_N-1:0] samp;

`ifdef KEYPAD_SYNC_EN
    logic [1:0][KEY_N-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], kp.keypad};
    end

    assign samp = sync_q[1];
`else
    assign samp = kp.keypad;
`endif

    logic               hit;
    logic [DIGIT_W-1:0] code;
    logic               any_key;

    keypad_onehot_enc u_enc (
        .sample_i (samp),
        .hit_o    (hit),
        .code_o   (code)
    );

    assign any_key = |samp;

    kp_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIGIT_W-1:0]    cand_q, cand_d;
    logic [2:0][DIGIT_W-1:0] digits_q, digits_d;   // [2]=Minutes [1]=TenSec [0]=Sec
    logic [DIGIT_W-1:0]    key_code_q, key_code_d;
    logic                  key_valid_q, key_valid_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        digits_d    = digits_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (hit && !kp.enablen) begin
                    state_d = PRESS;
                    cand_d  = code;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS: begin
                if (hit && (code == cand_q) && !kp.enablen) begin
                    // cnt_q counts matching samples so far; this one makes DEBOUNCE_CYCLES
                    if (cnt_q == CNT_LAST) begin
                        state_d     = HELD;
                        cnt_d       = '0;
                        digits_d    = {digits_q[1:0], cand_q};
                        key_code_d  = cand_q;
                        key_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            HELD: begin
                if (!any_key) begin
                    state_d = RELEASE;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE: begin
                // Any activity during release goes back to HELD, so bounce cannot re-commit
                if (any_key) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (kp.clear) begin
            digits_d    = {BCD_ZERO, BCD_ZERO, BCD_ZERO};
            key_code_d  = BCD_ZERO;
            key_valid_d = 1'b0;
            cnt_d       = '0;
            state_d     = any_key ? HELD : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= BCD_ZERO;
            digits_q    <= {BCD_ZERO, BCD_ZERO, BCD_ZERO};
            key_code_q  <= BCD_ZERO;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            digits_q    <= digits_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign kp.Minutes   = digits_q[2];
    assign kp.TenSec    = digits_q[1];
    assign kp.Sec       = digits_q[0];
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: directed keypad scenarios, a time-value model and literal pins.
module tb_keypad_encoder;
    import keypad_pkg::*;

    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    keypad_encoder_if kp();

    keypad_encoder #(.DEBOUNCE_CYCLES(DB), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp.slave)
    );

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int strobes  = 0;
    int last_strobe = -1;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model: entered time kept as one integer 0..999, keys shifted in decimally.
    // A press qualifies after DB consecutive identical single-key samples while enabled;
    // after a commit the pad must read empty for DB consecutive samples to re-arm.
    int m_val, m_code, m_run, m_rel, m_cand;
    bit m_armed, m_strobe;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_val <= 0; m_code <= 0; m_run <= 0; m_rel <= 0; m_cand <= 0;
            m_armed <= 1'b1; m_strobe <= 1'b0;
        end else begin : mdl
            automatic int val   = m_val;
            automatic int code  = m_code;
            automatic int run   = m_run;
            automatic int rel   = m_rel;
            automatic int cand  = m_cand;
            automatic bit armed = m_armed;
            automatic bit strb  = 1'b0;
            automatic int ones  = $countones(kp.keypad);
            automatic int k     = 0;
            for (int i = 0; i < KEY_N; i++) if (kp.keypad[i]) k = i;

            if (kp.clear) begin
                val = 0; code = 0; run = 0; rel = 0;
                armed = (ones == 0);
            end else if (armed) begin
                if (ones == 1 && !kp.enablen && (run == 0 || k == cand)) begin
                    if (run == 0) cand = k;
                    run++;
                    if (run == DB) begin
                        val = (val * 10 + cand) % 1000;
                        code = cand; strb = 1'b1;
                        armed = 1'b0; rel = 0; run = 0;
                    end
                end else begin
                    run = 0;
                end
            end else begin
                if (ones == 0) begin
                    rel++;
                    if (rel == DB) begin armed = 1'b1; run = 0; end
                end else begin
                    rel = 0;
                end
            end

            m_val <= val; m_code <= code; m_run <= run; m_rel <= rel;
            m_cand <= cand; m_armed <= armed; m_strobe <= strb;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("Minutes",   kp.Minutes,   m_val / 100);
            chk("TenSec",    kp.TenSec,    (m_val / 10) % 10);
            chk("Sec",       kp.Sec,       m_val % 10);
            chk("key_code",  kp.key_code,  m_code);
            chk("key_valid", kp.key_valid, m_strobe);
            if (kp.key_valid) begin
                strobes++;
                last_strobe = cyc;
            end
        end
    end

    function automatic logic [KEY_N-1:0] key(input int d);
        logic [KEY_N-1:0] one;
        one = KEY_N'(1);
        return one << d;
    endfunction

    task automatic hold(input logic [KEY_N-1:0] k, input int n);
        kp.keypad = k;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int s0, t0;
        rst_n = 1'b0;
        kp.keypad = '0; kp.enablen = 1'b0; kp.clear = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_Minutes",   kp.Minutes,   0);
        chk("rst_TenSec",    kp.TenSec,    0);
        chk("rst_Sec",       kp.Sec,       0);
        chk("rst_key_code",  kp.key_code,  0);
        chk("rst_key_valid", kp.key_valid, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // keys 1,2,3 then 4 shifted in from the right
        s0 = strobes;
        for (int d = 1; d <= 3; d++) begin
            hold(key(d), 6); hold('0, 6);
        end
        #1;
        chk("s1_strobes_123", strobes - s0, 3);
        chk("s1_Minutes_1", kp.Minutes, 1);
        chk("s1_TenSec_2",  kp.TenSec,  2);
        chk("s1_Sec_3",     kp.Sec,     3);
        hold(key(4), 6); hold('0, 6);
        #1;
        chk("s1_strobes_total", strobes - s0, 4);
        chk("s1_Minutes_2", kp.Minutes,  2);
        chk("s1_TenSec_3",  kp.TenSec,   3);
        chk("s1_Sec_4",     kp.Sec,      4);
        chk("s1_code_4",    kp.key_code, 4);

        // short bouncy press of key 5
        s0 = strobes;
        hold(key(5), 2); hold('0, 1); hold(key(5), 2); hold('0, 6);
        #1;
        chk("s2_no_strobe", strobes - s0, 0);
        chk("s2_Sec_hold",  kp.Sec, 4);

        // keys 0 and 4 together, then key 4 alone
        s0 = strobes;
        hold(10'b0000010001, 10);
        #1;
        chk("s3_multi_no_strobe", strobes - s0, 0);
        hold(key(4), 4); hold('0, 6);
        #1;
        chk("s3_one_strobe", strobes - s0, 1);
        chk("s3_Sec_4",      kp.Sec, 4);
        chk("s3_Minutes_3",  kp.Minutes, 3);

        // long hold of key 7 with release bounce
        s0 = strobes; t0 = cyc;
        hold(key(7), 20); hold('0, 1); hold(key(7), 1); hold('0, 1); hold(key(7), 1); hold('0, 6);
        #1;
        chk("s4_one_strobe",  strobes - s0, 1);
        chk("s4_strobe_edge", last_strobe - t0, 4);
        chk("s4_Sec_7",       kp.Sec, 7);

        // clear at edge 3 of a key 9 press
        s0 = strobes;
        hold(key(9), 2);
        kp.clear = 1'b1; hold(key(9), 1); kp.clear = 1'b0;
        #1;
        chk("s5_clr_Minutes", kp.Minutes,  0);
        chk("s5_clr_TenSec",  kp.TenSec,   0);
        chk("s5_clr_Sec",     kp.Sec,      0);
        chk("s5_clr_code",    kp.key_code, 0);
        hold(key(9), 10); hold('0, 6);
        #1;
        chk("s5_held_no_commit", strobes - s0, 0);
        hold(key(9), 6); hold('0, 6);
        #1;
        chk("s5_repress_commit", strobes - s0, 1);
        chk("s5_Sec_9", kp.Sec, 9);
        // clear coinciding with the committing edge
        s0 = strobes;
        hold(key(2), 3);
        kp.clear = 1'b1; hold(key(2), 1); kp.clear = 1'b0;
        hold('0, 6);
        #1;
        chk("s5_clr_wins_strobe", strobes - s0, 0);
        chk("s5_clr_wins_Sec",    kp.Sec, 0);

        // asynchronous reset mid-press with Sec=6
        hold(key(6), 6); hold('0, 6);
        #1;
        chk("s6_Sec_6", kp.Sec, 6);
        hold(key(6), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_async_Sec",       kp.Sec,       0);
        chk("s6_async_key_code",  kp.key_code,  0);
        chk("s6_async_key_valid", kp.key_valid, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        s0 = strobes; t0 = cyc;
        hold(key(6), 6); hold('0, 6);
        #1;
        chk("s6_requal_strobe", strobes - s0, 1);
        chk("s6_requal_edge",   last_strobe - t0, 4);
        chk("s6_requal_Sec",    kp.Sec, 6);

        // enablen blocks and aborts a key 8 press
        s0 = strobes;
        hold(key(8), 2);
        kp.enablen = 1'b1;
        hold(key(8), 6);
        #1;
        chk("s7_blocked", strobes - s0, 0);
        kp.enablen = 1'b0; t0 = cyc;
        hold(key(8), 6); hold('0, 6);
        #1;
        chk("s7_commit",      strobes - s0, 1);
        chk("s7_commit_edge", last_strobe - t0, 4);
        chk("s7_code_8",      kp.key_code, 8);
        chk("s7_TenSec_6",    kp.TenSec, 6);
        chk("s7_Sec_8",       kp.Sec, 8);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
